// File: rtl/regfile_sb.sv
// Integer register file with two combinational read ports, one write port,
// optional write-to-read bypass and a scoreboard of pending writes.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] rs1_out,
  output logic [XLEN-1:0] rs2_out,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            write_enable,
  input  logic [AW-1:0]   select,
  input  logic [XLEN-1:0] data_in,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  output logic [AW:0]     pending
);

  logic [XLEN-1:0]            regs [NREGS];
  logic [NREGS-1:0]           busy, busy_nxt;
  logic [AW:0]                cnt;
  logic                       we_ok, iss_ok;
  logic [1:0][AW-1:0]         ra;
  logic [1:0][XLEN-1:0]       rd;
  logic [1:0]                 bz;

  assign we_ok  = write_enable && !((ZERO_REG != 0) && (select == '0));
  assign iss_ok = issue_en && !((ZERO_REG != 0) && (issue_rd == '0));

  // Issue is applied after writeback so a same-register collision stays busy.
  always_comb begin
    busy_nxt = busy;
    if (we_ok)  busy_nxt[select]   = 1'b0;
    if (iss_ok) busy_nxt[issue_rd] = 1'b1;
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NREGS; i++)
      cnt = cnt + {{AW{1'b0}}, busy_nxt[i]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we_ok) begin
      regs[select] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy    <= '0;
      pending <= '0;
    end else begin
      busy    <= busy_nxt;
      pending <= cnt;
    end
  end

  assign ra = {rs2, rs1};

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic zr, hit;
    // Bypass is suppressed while reset is held so outputs read as cleared.
    assign zr  = (ZERO_REG != 0) && (ra[p] == '0);
    assign hit = (BYPASS != 0) && we_ok && !rst && (select == ra[p]);
    assign rd[p] = zr ? '0 : (hit ? data_in : regs[ra[p]]);
    assign bz[p] = zr ? 1'b0 : (hit ? 1'b0 : busy[ra[p]]);
  end

  assign rs1_out  = rd[0];
  assign rs2_out  = rd[1];
  assign rs1_busy = bz[0];
  assign rs2_busy = bz[1];

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: default, no-zero/no-bypass and 64x16 instances,
// checked against a plain array model plus explicit vector tables.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1, rs2, sel, ird;
  logic        we, iss;
  logic [31:0] din;

  logic [31:0] o1_0, o2_0, o1_1, o2_1;
  logic        b1_0, b2_0, b1_1, b2_1;
  logic [5:0]  p0, p1;

  logic [3:0]  a1, a2, s2, ir2;
  logic        w2, i2;
  logic [63:0] d2, q1_2, q2_2;
  logic        c1_2, c2_2;
  logic [4:0]  p2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_sb u0 (.clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rs1_out(o1_0), .rs2_out(o2_0),
    .rs1_busy(b1_0), .rs2_busy(b2_0), .write_enable(we), .select(sel), .data_in(din),
    .issue_en(iss), .issue_rd(ird), .pending(p0));

  regfile_sb #(.ZERO_REG(0), .BYPASS(0)) u1 (.clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2),
    .rs1_out(o1_1), .rs2_out(o2_1), .rs1_busy(b1_1), .rs2_busy(b2_1), .write_enable(we),
    .select(sel), .data_in(din), .issue_en(iss), .issue_rd(ird), .pending(p1));

  regfile_sb #(.XLEN(64), .NREGS(16)) u2 (.clk(clk), .rst(rst), .rs1(a1), .rs2(a2),
    .rs1_out(q1_2), .rs2_out(q2_2), .rs1_busy(c1_2), .rs2_busy(c2_2), .write_enable(w2),
    .select(s2), .data_in(d2), .issue_en(i2), .issue_rd(ir2), .pending(p2));

  // Model: index 0 = u0 (zero reg, bypass), index 1 = u1 (neither)
  logic [31:0] m_reg [2][32];
  logic        m_busy [2][32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_clear();
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < 32; r++) begin
        m_reg[k][r] = '0;
        m_busy[k][r] = 1'b0;
      end
  endtask

  function automatic logic [31:0] m_out(input int k, input logic [4:0] a);
    if (k == 0 && a == 0) return '0;
    if (k == 0 && we && sel == a) return din;
    return m_reg[k][a];
  endfunction

  function automatic logic m_bsy(input int k, input logic [4:0] a);
    if (k == 0 && a == 0) return 1'b0;
    if (k == 0 && we && sel == a) return 1'b0;
    return m_busy[k][a];
  endfunction

  function automatic int m_pend(input int k);
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(m_busy[k][r]);
    return n;
  endfunction

  // Inputs already applied; check reads, clock once, update model, check pending.
  task automatic cycle();
    #1;
    chk("u0_rs1_out", o1_0, m_out(0, rs1));  chk("u0_rs2_out", o2_0, m_out(0, rs2));
    chk("u0_rs1_busy", b1_0, m_bsy(0, rs1)); chk("u0_rs2_busy", b2_0, m_bsy(0, rs2));
    chk("u1_rs1_out", o1_1, m_out(1, rs1));  chk("u1_rs2_out", o2_1, m_out(1, rs2));
    chk("u1_rs1_busy", b1_1, m_bsy(1, rs1)); chk("u1_rs2_busy", b2_1, m_bsy(1, rs2));
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (we && !(k == 0 && sel == 0)) begin
        m_reg[k][sel] = din;
        m_busy[k][sel] = 1'b0;
      end
      if (iss && !(k == 0 && ird == 0)) m_busy[k][ird] = 1'b1;
    end
    #1;
    chk("u0_pending", 64'(p0), 64'(m_pend(0)));
    chk("u1_pending", 64'(p1), 64'(m_pend(1)));
  endtask

  typedef struct {
    logic        we;  logic [4:0] sel; logic [31:0] din;
    logic        iss; logic [4:0] ird;
    logic [4:0]  rs1; logic [4:0] rs2;
    logic [31:0] e1;  logic [31:0] e2;
    logic        eb1; logic eb2;
    int          ep;
  } vec_t;

  vec_t tbl [10];

  function automatic logic [63:0] pat(input int i);
    return 64'h0123_4567_89AB_CDEF ^ (64'(i) * 64'h1111_1111_1111_1111);
  endfunction

  initial begin
    //           we sel din            iss ird rs1 rs2 e1             e2             eb1 eb2 ep
    tbl[0] = '{0, 0, 32'h0,          1, 3,  3,  0,  32'h0,         32'h0,         0,  0,  1};
    tbl[1] = '{0, 0, 32'h0,          1, 4,  3,  4,  32'h0,         32'h0,         1,  0,  2};
    tbl[2] = '{1, 3, 32'h11,         0, 0,  3,  4,  32'h11,        32'h0,         0,  1,  1};
    tbl[3] = '{0, 0, 32'h0,          0, 0,  3,  4,  32'h11,        32'h0,         0,  1,  1};
    tbl[4] = '{0, 0, 32'h0,          1, 9,  9,  0,  32'h0,         32'h0,         0,  0,  2};
    tbl[5] = '{1, 9, 32'h55,         1, 9,  9,  9,  32'h55,        32'h55,        0,  0,  2};
    tbl[6] = '{0, 0, 32'h0,          0, 0,  9,  0,  32'h55,        32'h0,         1,  0,  2};
    tbl[7] = '{1, 0, 32'h12345678,   1, 0,  0,  0,  32'h0,         32'h0,         0,  0,  2};
    tbl[8] = '{1, 7, 32'hA5A5A5A5,   0, 0,  7,  7,  32'hA5A5A5A5,  32'hA5A5A5A5,  0,  0,  2};
    tbl[9] = '{1, 4, 32'h44,         0, 0,  4,  7,  32'h44,        32'hA5A5A5A5,  0,  0,  1};

    rst = 1'b1; we = 0; sel = 0; din = 0; iss = 0; ird = 0; rs1 = 0; rs2 = 0;
    w2 = 0; s2 = 0; d2 = 0; i2 = 0; ir2 = 0; a1 = 0; a2 = 0;
    m_clear();
    #3;
    chk("reset_pending", 64'(p0), 64'd0);
    chk("reset_rs1_out", o1_0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      we = tbl[i].we; sel = tbl[i].sel; din = tbl[i].din;
      iss = tbl[i].iss; ird = tbl[i].ird; rs1 = tbl[i].rs1; rs2 = tbl[i].rs2;
      #1;
      chk($sformatf("tbl%0d_rs1_out", i), o1_0, tbl[i].e1);
      chk($sformatf("tbl%0d_rs2_out", i), o2_0, tbl[i].e2);
      chk($sformatf("tbl%0d_rs1_busy", i), b1_0, tbl[i].eb1);
      chk($sformatf("tbl%0d_rs2_busy", i), b2_0, tbl[i].eb2);
      if (i == 8) chk("nobypass_old_r7", o1_1, 32'h0);
      cycle();
      chk($sformatf("tbl%0d_pending", i), 64'(p0), 64'(tbl[i].ep));
    end

    // Without a zero register r0 holds data; without bypass r7 shows after the edge.
    we = 0; iss = 0; rs1 = 0; rs2 = 7; #1;
    chk("u1_r0_data", o1_1, 32'h12345678);
    chk("u1_r7_after_edge", o2_1, 32'hA5A5A5A5);
    chk("u0_r0_zero", o1_0, 32'h0);
    cycle();

    // Asynchronous reset with no clock edge.
    we = 1; sel = 5; din = 32'hDEADBEEF; iss = 1; ird = 6;
    cycle();
    we = 0; iss = 0; rs1 = 5; rs2 = 6; #1;
    chk("pre_reset_r5", o1_0, 32'hDEADBEEF);
    rst = 1'b1; #1;
    chk("async_reset_r5", o1_0, 32'h0);
    chk("async_reset_busy6", b2_0, 1'b0);
    chk("async_reset_pending", 64'(p0), 64'd0);
    rst = 1'b0;
    m_clear();
    cycle();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      we  = 1'($urandom_range(0, 1));
      iss = 1'($urandom_range(0, 1));
      sel = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      ird = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      rs1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      rs2 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      din = $urandom;
      cycle();
    end
    we = 0; iss = 0;

    // 64-bit x 16 instance: fill, read back, then issue every register.
    for (int i = 0; i < 16; i++) begin
      w2 = 1; s2 = 4'(i); d2 = pat(i);
      @(posedge clk); #1;
    end
    w2 = 0;
    for (int i = 0; i < 16; i++) begin
      a1 = 4'(i); a2 = 4'(15 - i); #1;
      chk($sformatf("u2_rd1_r%0d", i), q1_2, (i == 0) ? 64'h0 : pat(i));
      chk($sformatf("u2_rd2_r%0d", 15 - i), q2_2, (i == 15) ? 64'h0 : pat(15 - i));
    end
    for (int i = 0; i < 16; i++) begin
      i2 = 1; ir2 = 4'(i);
      @(posedge clk); #1;
    end
    i2 = 0; a1 = 5; a2 = 0; #1;
    chk("u2_pending_full", 64'(p2), 64'd15);
    chk("u2_busy_r5", c1_2, 1'b1);
    chk("u2_busy_r0", c2_2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
